// File: rtl/scan_bist_pkg.sv
// Shared types and default constants for the scan BIST controller.
// The PRPG and the MISR use the same polynomial.
package scan_bist_pkg;

    localparam int              DEFAULT_SIG_W = 16;
    localparam logic [15:0]     DEFAULT_POLY  = 16'h002D;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD,
        DONE
    } bist_state_t;

    typedef enum logic {
        LFSR_AUTO,
        LFSR_SERIAL
    } lfsr_mode_t;

endpackage

// File: rtl/scan_bist_lfsr.sv
// One Galois LFSR step. In autonomous mode it generates patterns (PRPG).
// In serial-input mode it also folds serial_in into bit 0 (MISR).
module scan_bist_lfsr
    import scan_bist_pkg::*;
#(
    parameter int           W    = DEFAULT_SIG_W,
    parameter logic [W-1:0] POLY = W'(DEFAULT_POLY)
) (
    input  lfsr_mode_t   mode,
    input  logic [W-1:0] cur,
    input  logic         serial_in,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = {cur[W-2:0], 1'b0} ^ (cur[W-1] ? POLY : '0);
        if (mode == LFSR_SERIAL) begin
            nxt[0] = nxt[0] ^ serial_in;
        end
    end

endmodule

// File: rtl/scan_bist_ctrl.sv
// Scan BIST controller: drives the core scan chain from a PRPG, pulses capture,
// and compacts scan_out into a MISR whose value is reported as the signature.
module scan_bist_ctrl
    import scan_bist_pkg::*;
#(
    parameter int               CHAIN_LEN = 228,
    parameter int               SIG_W     = DEFAULT_SIG_W,
    parameter logic [SIG_W-1:0] POLY      = SIG_W'(DEFAULT_POLY),
    parameter int               PAT_W     = 16
) (
    input  logic             CK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] num_patterns,
    input  logic [SIG_W-1:0] seed,
    input  logic             scan_out,
    output logic             scan_en,
    output logic             scan_in,
    output logic             busy,
    output logic             done,
    output logic [PAT_W-1:0] pat_cnt,
    output logic [SIG_W-1:0] signature
);

    localparam int              CNT_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    bist_state_t      state, state_d;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [PAT_W-1:0] pat_cnt_d, pat_inc, num_pat_q;
    logic [SIG_W-1:0] prpg, prpg_d, prpg_step_val;
    logic [SIG_W-1:0] misr_d, misr_step_val;
    logic [SIG_W-1:0] seed_eff;
    logic             run_start;

    scan_bist_lfsr #(.W(SIG_W), .POLY(POLY)) u_prpg (
        .mode      (LFSR_AUTO),
        .cur       (prpg),
        .serial_in (1'b0),
        .nxt       (prpg_step_val)
    );

    scan_bist_lfsr #(.W(SIG_W), .POLY(POLY)) u_misr (
        .mode      (LFSR_SERIAL),
        .cur       (signature),
        .serial_in (scan_out),
        .nxt       (misr_step_val)
    );

    // An all-zero seed would lock the PRPG at zero forever.
    assign seed_eff = (seed == '0) ? SIG_W'(1) : seed;

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        pat_cnt_d = pat_cnt;
        prpg_d    = prpg;
        misr_d    = signature;
        run_start = 1'b0;
        pat_inc   = pat_cnt + PAT_W'(1);

        if (abort) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        run_start = 1'b1;
                        prpg_d    = seed_eff;
                        misr_d    = '0;
                        pat_cnt_d = '0;
                        bit_cnt_d = '0;
                        state_d   = (num_patterns == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    prpg_d = prpg_step_val;
                    // The first load unloads uninitialised core state, so it is not compacted.
                    if (pat_cnt != '0) begin
                        misr_d = misr_step_val;
                    end
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = CAPTURE;
                    end else begin
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    pat_cnt_d = pat_inc;
                    state_d   = (pat_inc == num_pat_q) ? UNLOAD : SHIFT;
                end
                UNLOAD: begin
                    misr_d = misr_step_val;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            pat_cnt   <= '0;
            num_pat_q <= '0;
            prpg      <= SIG_W'(1);
            signature <= '0;
            scan_en   <= 1'b0;
            scan_in   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            pat_cnt   <= pat_cnt_d;
            prpg      <= prpg_d;
            signature <= misr_d;
            if (run_start) begin
                num_pat_q <= num_patterns;
            end
            scan_en <= (state_d == SHIFT) || (state_d == UNLOAD);
            scan_in <= (state_d == SHIFT) ? prpg_d[SIG_W-1] : 1'b0;
            busy    <= (state_d == SHIFT) || (state_d == CAPTURE) || (state_d == UNLOAD);
            done    <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Self-checking bench for scan_bist_ctrl: a short-chain instance for directed
// vectors and corner cases, and a full-length instance driven through a loopback chain.
module tb_scan_bist_ctrl;

    localparam int          TRACE_LEN = 64;
    localparam int          LB_CHAIN  = 228;
    localparam int          LB_PATS   = 100;
    localparam int          LB_MAX    = LB_PATS * (LB_CHAIN + 1) + LB_CHAIN;
    localparam logic [15:0] POLY      = 16'h002D;

    typedef struct {
        logic [15:0] n;
        logic [15:0] seed;
        logic        so;
        logic [15:0] exp_sig;
        logic [15:0] exp_pat;
        int          exp_busy;
    } vec_t;

    logic        CK = 1'b0;
    logic        RST_N = 1'b0;

    logic        start_s = 1'b0, abort_s = 1'b0, so_s = 1'b0;
    logic [15:0] np_s = '0, seed_s = '0;
    logic        se_s, si_s, busy_s, done_s;
    logic [15:0] pc_s, sig_s;

    logic        start_l = 1'b0, abort_l = 1'b0, so_l;
    logic [15:0] np_l = '0, seed_l = '0;
    logic        se_l, si_l, busy_l, done_l;
    logic [15:0] pc_l, sig_l;

    logic [LB_CHAIN-1:0] dly = '0;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic se_tr [0:TRACE_LEN-1];
    logic si_tr [0:TRACE_LEN-1];
    bit   lb_si  [0:LB_MAX-1];
    bit   lb_cmp [0:LB_MAX-1];
    vec_t vecs [6];

    always #5 CK = ~CK;

    scan_bist_ctrl #(.CHAIN_LEN(4)) dut_s (
        .CK(CK), .RST_N(RST_N), .start(start_s), .abort(abort_s),
        .num_patterns(np_s), .seed(seed_s), .scan_out(so_s),
        .scan_en(se_s), .scan_in(si_s), .busy(busy_s), .done(done_s),
        .pat_cnt(pc_s), .signature(sig_s)
    );

    scan_bist_ctrl #(.CHAIN_LEN(LB_CHAIN)) dut_l (
        .CK(CK), .RST_N(RST_N), .start(start_l), .abort(abort_l),
        .num_patterns(np_l), .seed(seed_l), .scan_out(so_l),
        .scan_en(se_l), .scan_in(si_l), .busy(busy_l), .done(done_l),
        .pat_cnt(pc_l), .signature(sig_l)
    );

    // Stand-in for the core chain: scan_out is scan_in delayed by the chain length.
    always @(posedge CK) dly <= {dly[LB_CHAIN-2:0], si_l};
    assign so_l = dly[LB_CHAIN-1];

    function automatic logic [15:0] galois(input logic [15:0] v);
        return {v[14:0], 1'b0} ^ (v[15] ? POLY : 16'h0000);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v, output int busy_cycles, output int done_at);
        @(negedge CK);
        np_s = v.n; seed_s = v.seed; so_s = v.so; start_s = 1'b1;
        @(negedge CK);
        start_s = 1'b0;
        busy_cycles = 0;
        done_at = -1;
        for (int c = 1; c < TRACE_LEN; c++) begin
            se_tr[c] = se_s;
            si_tr[c] = si_s;
            if (busy_s) busy_cycles++;
            if (done_s) begin
                done_at = c;
                break;
            end
            @(negedge CK);
        end
    endtask

    // Expected PRPG stream over the shift cycles of a CHAIN_LEN=4 run.
    function automatic logic [31:0] prpgStream(input logic [15:0] sd, input int nbits);
        logic [15:0] p = (sd == 16'h0000) ? 16'h0001 : sd;
        logic [31:0] r = '0;
        for (int i = 0; i < nbits; i++) begin
            r = {r[30:0], p[15]};
            p = galois(p);
        end
        return r;
    endfunction

    function automatic logic [31:0] shiftBits(input int npat);
        logic [31:0] r = '0;
        for (int p = 0; p < npat; p++)
            for (int b = 0; b < 4; b++)
                r = {r[30:0], si_tr[1 + p * 5 + b]};
        return r;
    endfunction

    task automatic computeLoopback(input int npat, input logic [15:0] sd, output logic [15:0] sig);
        logic [15:0] p = (sd == 16'h0000) ? 16'h0001 : sd;
        logic [15:0] m = '0;
        int t = 0;
        bit so;
        for (int k = 0; k < npat; k++) begin
            for (int b = 0; b < LB_CHAIN; b++) begin
                lb_si[t] = p[15]; lb_cmp[t] = (k > 0); p = galois(p); t++;
            end
            lb_si[t] = 1'b0; lb_cmp[t] = 1'b0; t++;
        end
        for (int b = 0; b < LB_CHAIN; b++) begin
            lb_si[t] = 1'b0; lb_cmp[t] = 1'b1; t++;
        end
        for (int i = 0; i < t; i++) begin
            so = (i >= LB_CHAIN) ? lb_si[i - LB_CHAIN] : 1'b0;
            if (lb_cmp[i]) m = galois(m) ^ {15'd0, so};
        end
        sig = m;
    endtask

    initial begin
        int          busy_c, done_at, seen, cyc;
        logic [15:0] lb_exp;

        vecs[0] = '{16'd1, 16'h0001, 1'b1, 16'h000F, 16'd1,  9};
        vecs[1] = '{16'd2, 16'h0001, 1'b1, 16'h00FF, 16'd2, 14};
        vecs[2] = '{16'd0, 16'h0001, 1'b1, 16'h0000, 16'd0,  0};
        vecs[3] = '{16'd3, 16'hBEEF, 1'b1, 16'h0FFF, 16'd3, 19};
        vecs[4] = '{16'd1, 16'h0001, 1'b0, 16'h0000, 16'd1,  9};
        vecs[5] = '{16'd5, 16'h1234, 1'b1, 16'hFE54, 16'd5, 29};

        repeat (3) @(negedge CK);
        checkOutput("reset_scan_en", 32'(se_s), 32'd0);
        checkOutput("reset_busy", 32'(busy_s), 32'd0);
        checkOutput("reset_signature", 32'(sig_s), 32'd0);
        RST_N = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], busy_c, done_at);
            checkOutput($sformatf("vec%0d_signature", i), 32'(sig_s), 32'(vecs[i].exp_sig));
            checkOutput($sformatf("vec%0d_pat_cnt", i), 32'(pc_s), 32'(vecs[i].exp_pat));
            checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(busy_c), 32'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_done_cycle", i), 32'(done_at), 32'(vecs[i].exp_busy + 1));
            @(negedge CK);
            checkOutput($sformatf("vec%0d_done_width", i), 32'(done_s), 32'd0);
        end

        // scan_en profile for one pattern: 4 shift, 1 capture, 4 unload, then done
        applyStimulus(vecs[0], busy_c, done_at);
        begin
            logic [9:0] se_bits = '0;
            for (int c = 1; c <= 10; c++) se_bits = {se_bits[8:0], se_tr[c]};
            checkOutput("scan_en_profile", 32'(se_bits), 32'(10'b1111011110));
        end

        applyStimulus('{16'd1, 16'h8000, 1'b1, 16'h0, 16'd0, 0}, busy_c, done_at);
        checkOutput("seed8000_first_shift", shiftBits(1), 32'(4'b1000));

        applyStimulus('{16'd5, 16'h0000, 1'b1, 16'h0, 16'd0, 0}, busy_c, done_at);
        checkOutput("seed0_stream", shiftBits(5), prpgStream(16'h0000, 20));
        applyStimulus('{16'd5, 16'h0001, 1'b1, 16'h0, 16'd0, 0}, busy_c, done_at);
        checkOutput("seed1_stream", shiftBits(5), prpgStream(16'h0001, 20));

        // abort in the third shift cycle of the first pattern
        @(negedge CK);
        np_s = 16'd3; seed_s = 16'h0001; so_s = 1'b1; start_s = 1'b1;
        @(negedge CK);
        start_s = 1'b0;
        @(negedge CK);
        @(negedge CK);
        checkOutput("abort_pre_scan_en", 32'(se_s), 32'd1);
        abort_s = 1'b1;
        @(negedge CK);
        abort_s = 1'b0;
        checkOutput("abort_scan_en", 32'(se_s), 32'd0);
        checkOutput("abort_busy", 32'(busy_s), 32'd0);
        checkOutput("abort_signature", 32'(sig_s), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (done_s || busy_s) seen++;
            @(negedge CK);
        end
        checkOutput("abort_no_done", 32'(seen), 32'd0);
        applyStimulus(vecs[0], busy_c, done_at);
        checkOutput("post_abort_signature", 32'(sig_s), 32'h000F);
        checkOutput("post_abort_done_cycle", 32'(done_at), 32'd10);

        // abort and start together in IDLE: run must not start
        @(negedge CK);
        np_s = 16'd2; start_s = 1'b1; abort_s = 1'b1;
        @(negedge CK);
        start_s = 1'b0; abort_s = 1'b0;
        checkOutput("abort_start_busy", 32'(busy_s), 32'd0);
        @(negedge CK);
        checkOutput("abort_start_scan_en", 32'(se_s), 32'd0);

        // start and num_patterns changes during a run are ignored
        @(negedge CK);
        np_s = 16'd1; so_s = 1'b1; start_s = 1'b1;
        @(negedge CK);
        np_s = 16'd7;
        @(negedge CK);
        start_s = 1'b0;
        cyc = 2;
        while (!done_s && cyc < 100) begin
            @(negedge CK);
            cyc++;
        end
        checkOutput("midrun_done_cycle", 32'(cyc), 32'd10);
        checkOutput("midrun_pat_cnt", 32'(pc_s), 32'd1);
        checkOutput("midrun_signature", 32'(sig_s), 32'h000F);

        // full-length loopback run
        computeLoopback(LB_PATS, 16'hACE1, lb_exp);
        @(negedge CK);
        np_l = 16'(LB_PATS); seed_l = 16'hACE1; start_l = 1'b1;
        @(negedge CK);
        start_l = 1'b0;
        cyc = 1;
        while (!done_l && cyc < 30000) begin
            @(negedge CK);
            cyc++;
        end
        checkOutput("loopback_done_cycle", 32'(cyc), 32'(LB_PATS * (LB_CHAIN + 1) + LB_CHAIN + 1));
        checkOutput("loopback_signature", 32'(sig_l), 32'(lb_exp));
        checkOutput("loopback_pat_cnt", 32'(pc_l), 32'(LB_PATS));

        // asynchronous reset in the middle of UNLOAD
        @(negedge CK);
        np_l = 16'd1; seed_l = 16'h0001; start_l = 1'b1;
        @(negedge CK);
        start_l = 1'b0;
        repeat (299) @(negedge CK);
        checkOutput("unload_scan_en", 32'(se_l), 32'd1);
        checkOutput("unload_pat_cnt", 32'(pc_l), 32'd1);
        RST_N = 1'b0;
        #1;
        checkOutput("rst_scan_en", 32'(se_l), 32'd0);
        checkOutput("rst_busy", 32'(busy_l), 32'd0);
        checkOutput("rst_done", 32'(done_l), 32'd0);
        checkOutput("rst_pat_cnt", 32'(pc_l), 32'd0);
        checkOutput("rst_signature", 32'(sig_l), 32'd0);
        @(negedge CK);
        RST_N = 1'b1;
        applyStimulus(vecs[1], busy_c, done_at);
        checkOutput("post_reset_signature", 32'(sig_s), 32'h00FF);
        checkOutput("post_reset_busy_cycles", 32'(busy_c), 32'd14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
